tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the execute-stage CSR/instruction logic and the TLB array. It drives the array's search, read and write ports and returns registered results plus a one-cycle `done` pulse. INVTLB is carried out as an index sweep over every entry: read, match, then clear `e`. The TLB array itself therefore holds no invalidation logic.

## Interface
- `TLBNUM`, 16: number of TLB entries; must be a power of two. `IW` = $clog2(TLBNUM).
- `clk` in 1: clock.
- `resetn` in 1: one clock; reset is synchronous and active-low.
- `op_valid` in 1 / `op_ready` out 1: operation handshake. `op_ready`=1 only in IDLE.
- `op_code` in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 illegal.
- `inv_op` in 5, `inv_asid` in 10, `inv_vppn` in 19: INVTLB operands.
- `csr_index` in IW, `csr_ne` in 1, `csr_ps` in 6, `csr_vppn` in 19, `csr_asid` in 10, `csr_g` in 1: TLBIDX/TLBEHI/ASID fields.
- `csr_lo0` in 26, `csr_lo1` in 26: packed {ppn[19:0], plv[1:0], mat[1:0], d, v}.
- `s_vppn` out 19, `s_asid` out 10, `s_found` in 1, `s_index` in IW: TLB search port.
- `r_index` out IW; `r_e`, `r_vppn`, `r_ps`, `r_asid`, `r_g`, `r_lo0`, `r_lo1` in: TLB read port, combinational, with the same widths as above.
- `we` out 1, `w_index` out IW, `w_e` out 1, `w_vppn` out 19, `w_ps` out 6, `w_asid` out 10, `w_g` out 1, `w_lo0` out 26, `w_lo1` out 26: TLB write port.
- `done` out 1: one-cycle completion pulse. `err` out 1: illegal op flag, valid with `done`.
- `res_hit` out 1, `res_index` out IW: SRCH result.
- `res_e`, `res_vppn`, `res_ps`, `res_asid`, `res_g`, `res_lo0`, `res_lo1` out: RD result.

## Operation
- States: IDLE, SRCH, RD, WR, INV, DONE.
- Accepting an operation:
  - On `op_valid && op_ready` all operands are latched.
  - op 0/1/2 go to SRCH/RD/WR respectively.
  - FILL goes to WR with index = `fill_ctr`.
  - INV with `inv_op` ≤ 6 goes to INV with `sweep_idx`=0.
  - Illegal `op_code`, or `inv_op` > 6, goes straight to DONE with `err`=1 and no port activity.
- SRCH:
  - Drives `s_vppn`/`s_asid` from the latched `csr_vppn`/`csr_asid`.
  - Captures `res_hit`=`s_found`. `res_index` = `s_index` on a hit; on a miss it holds its previous value.
  - Goes to DONE.
- RD:
  - `r_index`=latched `csr_index`; all `r_*` are captured into `res_*`.
  - `r_e`=0 forces `res_e`=0, with the other `res_*` fields still captured.
  - Goes to DONE.
- WR (covers both WR and FILL):
  - `we`=1 for exactly one cycle.
  - `w_e`=~`csr_ne`; the other `w_*` fields come from the latched CSR fields.
  - Goes to DONE.
- `fill_ctr`: free-running IW-bit counter, incremented every cycle and wrapping from TLBNUM-1 to 0. FILL samples it in the accept cycle.
- INV, one entry per cycle:
  - `r_index`=`sweep_idx`.
  - `va_m` = (`inv_vppn[18:10]`==`r_vppn[18:10]`) && (`r_ps`==22 || `inv_vppn[9:0]`==`r_vppn[9:0]`).
  - `asid_m` = (`inv_asid`==`r_asid`).
  - Match rule per `inv_op`:
    - 0 or 1: all entries.
    - 2: `r_g`.
    - 3: !`r_g`.
    - 4: !`r_g` && `asid_m`.
    - 5: !`r_g` && `asid_m` && `va_m`.
    - 6: (`r_g` || `asid_m`) && `va_m`.
  - When `r_e` && match: `we`=1, `w_index`=`sweep_idx`, `w_e`=0, and every other `w_*` field is the read-back value. Otherwise `we`=0.
  - `sweep_idx`==TLBNUM-1 goes to DONE; otherwise `sweep_idx`+1.
- DONE: `done`=1 for one cycle, then IDLE. `res_*` and `err` hold until the next DONE.
- When not in the owning state: `we`=0, and `s_*`, `r_index`, `w_*` are driven to 0.

## Timing
- Reset values:
  - state IDLE, `op_ready`=1, `done`=0, `err`=0, `we`=0, `fill_ctr`=0.
  - All `res_*` = 0; `s_*`, `r_index`, `w_*` = 0.
- Reset asserted mid-operation (including mid-sweep) aborts immediately. No further write is issued and no `done` is pulsed.
- Latency, with the accept at cycle T:
  - SRCH/RD/WR/FILL: port action at T+1, `done` at T+2, `op_ready` again at T+3.
  - INV: writes during T+1 .. T+TLBNUM, `done` at T+TLBNUM+1.
  - Illegal op: `done`=`err`=1 at T+1.
- Search and read ports are combinational inside the TLB; results are sampled at the end of the same cycle. Writes take effect at the next clock edge.
- An INV write to entry k never affects the read of entry k+1.

## Structure
- Shared package `tlb_pkg`:
  - `op_code` and `inv_op` encodings.
  - The packed `lo` layout (26 bits) with its field offsets.
  - State encoding, and `PS_4K`=12, `PS_4M`=22.
- Natural sub-module: `tlb_inv_match`, combinational. Inputs are `inv_op`, `inv_asid`, `inv_vppn` and the read-back entry; the single output is `match`.

## Test plan
- SRCH with entry 5 = {vppn 0x12345, asid 3, g 0, e 1} and CSR vppn 0x12345 / asid 3 → `done` at T+2, `res_hit`=1, `res_index`=5. With asid 4 → `res_hit`=0.
- WR, `csr_index`=7, `csr_ne`=0, ps 22 → one `we` pulse at T+1 with `w_index`=7, `w_e`=1, `w_ps`=22. A following RD of index 7 returns identical `res_*`.
- FILL twice, accepted 3 cycles apart, counter starting at 0 → `w_index` values 0 then 3. With TLBNUM=16 and 17 cycles between accepts, the index wraps correctly.
- INV with `inv_op`=5, asid 3, vppn 0x12345, over entries {g0/asid3/match, g1/match, g0/asid4/match} → only the first is cleared. `done` at T+17 for TLBNUM=16.
- INV with `inv_op`=7, and `op_code`=6 → `done`=`err`=1 at T+1 and `we` never asserts.
- `resetn` low at sweep index 8 → no `we` after the reset edge, state IDLE, `op_ready`=1, and entries 8–15 keep `e`=1.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared encodings for the TLB maintenance sequencer
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_code_e;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G          = 5'd2;
    localparam logic [4:0] INV_NG         = 5'd3;
    localparam logic [4:0] INV_NG_ASID    = 5'd4;
    localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA      = 5'd6;
    localparam logic [4:0] INV_MAX        = 5'd6;

    localparam int LO_W   = 26;
    localparam int LO_V   = 0;
    localparam int LO_D   = 1;
    localparam int LO_MAT = 2;
    localparam int LO_PLV = 4;
    localparam int LO_PPN = 6;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } lo_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH,
        S_RD,
        S_WR,
        S_INV,
        S_DONE
    } state_e;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd22;

    function automatic logic op_legal(input logic [2:0] code, input logic [4:0] iop);
        return (code <= OP_INV) && (code != OP_INV || iop <= INV_MAX);
    endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match: decides whether a read-back TLB entry is selected by an INVTLB operand set
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic [4:0]  inv_op,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_vppn,
    input  logic [18:0] e_vppn,
    input  logic [5:0]  e_ps,
    input  logic [9:0]  e_asid,
    input  logic        e_g,
    output logic        match
);

    logic va_m;
    logic asid_m;

    // a 4M page ignores the low vppn bits; then apply the per-inv_op selection rule
    always_comb begin
        va_m   = (inv_vppn[18:10] == e_vppn[18:10]) && (e_ps == PS_4M || inv_vppn[9:0] == e_vppn[9:0]);
        asid_m = (inv_asid == e_asid);
        match  = (inv_op == INV_ALL0 || inv_op == INV_ALL1) ? 1'b1 :
                 (inv_op == INV_G)          ? e_g :
                 (inv_op == INV_NG)         ? !e_g :
                 (inv_op == INV_NG_ASID)    ? (!e_g && asid_m) :
                 (inv_op == INV_NG_ASID_VA) ? (!e_g && asid_m && va_m) :
                 (inv_op == INV_GA_VA)      ? ((e_g || asid_m) && va_m) : 1'b0;
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB array ports
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    input  logic [IW-1:0] csr_index,
    input  logic          csr_ne,
    input  logic [5:0]    csr_ps,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic          csr_g,
    input  logic [25:0]   csr_lo0,
    input  logic [25:0]   csr_lo1,
    output logic [18:0]   s_vppn,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [25:0]   r_lo0,
    input  logic [25:0]   r_lo1,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [25:0]   w_lo0,
    output logic [25:0]   w_lo1,
    output logic          done,
    output logic          err,
    output logic          res_hit,
    output logic [IW-1:0] res_index,
    output logic          res_e,
    output logic [18:0]   res_vppn,
    output logic [5:0]    res_ps,
    output logic [9:0]    res_asid,
    output logic          res_g,
    output logic [25:0]   res_lo0,
    output logic [25:0]   res_lo1
);

    state_e        state;
    state_e        state_nx;
    logic [IW-1:0] fill_ctr;
    logic [IW-1:0] sweep_idx;
    logic [IW-1:0] l_index;
    logic          l_ne;
    logic [5:0]    l_ps;
    logic [18:0]   l_vppn;
    logic [9:0]    l_asid;
    logic          l_g;
    logic [25:0]   l_lo0;
    logic [25:0]   l_lo1;
    logic [4:0]    l_inv_op;
    logic [9:0]    l_inv_asid;
    logic [18:0]   l_inv_vppn;
    logic          accept;
    logic          match;

    assign op_ready = (state == S_IDLE);
    assign done     = (state == S_DONE);
    assign accept   = op_valid && op_ready;

    tlb_inv_match u_match (
        .inv_op   (l_inv_op),
        .inv_asid (l_inv_asid),
        .inv_vppn (l_inv_vppn),
        .e_vppn   (r_vppn),
        .e_ps     (r_ps),
        .e_asid   (r_asid),
        .e_g      (r_g),
        .match    (match)
    );

    // next state and port drive; writes are gated by resetn so a reset aborts without a final write
    always_comb begin
        state_nx = state;
        s_vppn   = '0;
        s_asid   = '0;
        r_index  = '0;
        we       = 1'b0;
        w_index  = '0;
        w_e      = 1'b0;
        w_vppn   = '0;
        w_ps     = '0;
        w_asid   = '0;
        w_g      = 1'b0;
        w_lo0    = '0;
        w_lo1    = '0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = !op_legal(op_code, inv_op) ? S_DONE :
                               (op_code == OP_SRCH)       ? S_SRCH :
                               (op_code == OP_RD)         ? S_RD   :
                               (op_code == OP_INV)        ? S_INV  : S_WR;
            end
            S_SRCH: begin
                s_vppn   = l_vppn;
                s_asid   = l_asid;
                state_nx = S_DONE;
            end
            S_RD: begin
                r_index  = l_index;
                state_nx = S_DONE;
            end
            S_WR: begin
                we       = resetn;
                w_index  = l_index;
                w_e      = ~l_ne;
                w_vppn   = l_vppn;
                w_ps     = l_ps;
                w_asid   = l_asid;
                w_g      = l_g;
                w_lo0    = l_lo0;
                w_lo1    = l_lo1;
                state_nx = S_DONE;
            end
            S_INV: begin
                r_index = sweep_idx;
                if (resetn && r_e && match) begin
                    we      = 1'b1;
                    w_index = sweep_idx;
                    w_vppn  = r_vppn;
                    w_ps    = r_ps;
                    w_asid  = r_asid;
                    w_g     = r_g;
                    w_lo0   = r_lo0;
                    w_lo1   = r_lo1;
                end
                state_nx = (sweep_idx == IW'(TLBNUM - 1)) ? S_DONE : S_INV;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // state, counters and result registers; err is only refreshed on entry to DONE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            fill_ctr  <= '0;
            sweep_idx <= '0;
            err       <= 1'b0;
            res_hit   <= 1'b0;
            res_index <= '0;
            res_e     <= 1'b0;
            res_vppn  <= '0;
            res_ps    <= '0;
            res_asid  <= '0;
            res_g     <= 1'b0;
            res_lo0   <= '0;
            res_lo1   <= '0;
        end else begin
            state    <= state_nx;
            fill_ctr <= fill_ctr + IW'(1);
            if (accept)
                sweep_idx <= '0;
            else if (state == S_INV)
                sweep_idx <= sweep_idx + IW'(1);
            if (state_nx == S_DONE)
                err <= (state == S_IDLE);
            if (state == S_SRCH) begin
                res_hit <= s_found;
                if (s_found)
                    res_index <= s_index;
            end
            if (state == S_RD) begin
                res_e    <= r_e;
                res_vppn <= r_vppn;
                res_ps   <= r_ps;
                res_asid <= r_asid;
                res_g    <= r_g;
                res_lo0  <= r_lo0;
                res_lo1  <= r_lo1;
            end
        end
    end

    // operands are captured on accept; FILL takes its index from the free-running counter
    always_ff @(posedge clk) begin
        if (accept) begin
            l_index    <= (op_code == OP_FILL) ? fill_ctr : csr_index;
            l_ne       <= csr_ne;
            l_ps       <= csr_ps;
            l_vppn     <= csr_vppn;
            l_asid     <= csr_asid;
            l_g        <= csr_g;
            l_lo0      <= csr_lo0;
            l_lo1      <= csr_lo1;
            l_inv_op   <= inv_op;
            l_inv_asid <= inv_asid;
            l_inv_vppn <= inv_vppn;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: randomized scoreboard bench with a behavioural TLB model
module tb_tlb_op_ctrl;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [25:0] lo0;
        logic [25:0] lo1;
    } ent_t;

    typedef struct packed {
        logic [2:0]  code;
        logic [4:0]  inv_op;
        logic [9:0]  inv_asid;
        logic [18:0] inv_vppn;
        logic [3:0]  idx;
        logic        ne;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [25:0] lo0;
        logic [25:0] lo1;
    } op_t;

    typedef struct {
        int       done_cyc;
        bit       err;
        int       writes;
        int       widx;
        bit       hit;
        int       idx;
        ent_t     rd;
    } exp_t;

    logic clk = 0, resetn = 0, op_valid = 0, op_ready;
    logic [2:0] op_code = 0;
    logic [4:0] inv_op = 0;
    logic [9:0] inv_asid = 0, csr_asid = 0, s_asid, r_asid, w_asid, res_asid;
    logic [18:0] inv_vppn = 0, csr_vppn = 0, s_vppn, r_vppn, w_vppn, res_vppn;
    logic [3:0] csr_index = 0, s_index, r_index, w_index, res_index;
    logic csr_ne = 0, csr_g = 0, s_found, r_e, r_g, we, w_e, w_g, done, err, res_hit, res_e, res_g;
    logic [5:0] csr_ps = 0, r_ps, w_ps, res_ps;
    logic [25:0] csr_lo0 = 0, csr_lo1 = 0, r_lo0, r_lo1, w_lo0, w_lo1, res_lo0, res_lo1;

    ent_t t_arr [16];
    ent_t m_arr [16];
    bit   load = 0;
    int   cyc = 0, checks = 0, errors = 0, rel_cyc = 0, wcnt = 0, lw = 0;
    exp_t q[$];
    bit   m_hit = 0;
    int   m_idx = 0;
    ent_t m_rd = '0;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_index(csr_index),
        .csr_ne(csr_ne), .csr_ps(csr_ps), .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_g(csr_g),
        .csr_lo0(csr_lo0), .csr_lo1(csr_lo1), .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found),
        .s_index(s_index), .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
        .r_asid(r_asid), .r_g(r_g), .r_lo0(r_lo0), .r_lo1(r_lo1), .we(we), .w_index(w_index),
        .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g), .w_lo0(w_lo0),
        .w_lo1(w_lo1), .done(done), .err(err), .res_hit(res_hit), .res_index(res_index),
        .res_e(res_e), .res_vppn(res_vppn), .res_ps(res_ps), .res_asid(res_asid), .res_g(res_g),
        .res_lo0(res_lo0), .res_lo1(res_lo1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit hit(input ent_t x, input logic [18:0] v, input logic [9:0] a);
        return x.e && x.vppn[18:10] == v[18:10] && (x.ps == 6'd22 || x.vppn[9:0] == v[9:0]) && (x.g || x.asid == a);
    endfunction

    // TLB array environment: combinational search/read, write at the clock edge
    always_comb begin
        s_found = 0;
        s_index = 0;
        for (int i = 15; i >= 0; i--)
            if (hit(t_arr[i], s_vppn, s_asid)) begin
                s_found = 1;
                s_index = 4'(i);
            end
    end
    assign {r_e, r_vppn, r_ps, r_asid, r_g, r_lo0, r_lo1} = t_arr[r_index];

    always @(posedge clk) begin
        if (load)
            for (int i = 0; i < 16; i++) t_arr[i] <= m_arr[i];
        else if (we)
            t_arr[w_index] <= {w_e, w_vppn, w_ps, w_asid, w_g, w_lo0, w_lo1};
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] pool_vppn();
        return {9'($urandom_range(0, 1)), 10'($urandom_range(0, 3))};
    endfunction

    function automatic op_t mk(input logic [2:0] code);
        op_t o;
        int j;
        j = $urandom_range(0, 15);
        o.code = code;
        o.inv_op = 5'($urandom_range(0, 7));
        o.inv_asid = $urandom_range(0, 1) ? m_arr[j].asid : 10'($urandom_range(0, 2));
        o.inv_vppn = $urandom_range(0, 1) ? m_arr[j].vppn : pool_vppn();
        o.idx = 4'($urandom_range(0, 15));
        o.ne = ($urandom_range(0, 3) == 0);
        o.ps = $urandom_range(0, 1) ? 6'd12 : 6'd22;
        o.vppn = $urandom_range(0, 1) ? m_arr[j].vppn : pool_vppn();
        o.asid = $urandom_range(0, 1) ? m_arr[j].asid : 10'($urandom_range(0, 2));
        o.g = 1'($urandom_range(0, 1));
        o.lo0 = 26'($urandom);
        o.lo1 = 26'($urandom);
        return o;
    endfunction

    function automatic op_t rnd_op();
        int r;
        r = $urandom_range(0, 19);
        return mk(r < 4 ? 3'd0 : r < 8 ? 3'd1 : r < 11 ? 3'd2 : r < 14 ? 3'd3 : r < 18 ? 3'd4 : 3'($urandom_range(5, 7)));
    endfunction

    task automatic drive(input op_t o);
        op_code = o.code; inv_op = o.inv_op; inv_asid = o.inv_asid; inv_vppn = o.inv_vppn;
        csr_index = o.idx; csr_ne = o.ne; csr_ps = o.ps; csr_vppn = o.vppn; csr_asid = o.asid;
        csr_g = o.g; csr_lo0 = o.lo0; csr_lo1 = o.lo1;
    endtask

    // reference model: applies the operation to the model array at accept time and queues the expectation
    task automatic issue(input op_t o, input bit push);
        exp_t x;
        int n, t, lat, w;
        bit m;
        ent_t e;
        logic [4:0] iop;
        n = 0;
        while (!op_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!op_ready) begin chk("op_ready_wait", op_ready, 1); return; end
        drive(o);
        op_valid = 1;
        t = cyc;
        lat = 2;
        x.err = 0; x.writes = 0; x.widx = -1;
        if (o.code > 4 || (o.code == 4 && o.inv_op > 6)) begin
            x.err = 1;
            lat = 1;
        end else if (o.code == 0) begin
            m_hit = 0;
            for (int i = 15; i >= 0; i--)
                if (hit(m_arr[i], o.vppn, o.asid)) begin m_hit = 1; m_idx = i; end
        end else if (o.code == 1) begin
            m_rd = m_arr[o.idx];
        end else if (o.code == 4) begin
            lat = 17;
            iop = o.inv_op;
            for (int i = 0; i < 16; i++) begin
                e = m_arr[i];
                case (iop)
                    0, 1: m = 1;
                    2: m = e.g;
                    3: m = !e.g;
                    4: m = !e.g && e.asid == o.inv_asid;
                    5: m = !e.g && e.asid == o.inv_asid && e.vppn[18:10] == o.inv_vppn[18:10] && (e.ps == 22 || e.vppn[9:0] == o.inv_vppn[9:0]);
                    default: m = (e.g || e.asid == o.inv_asid) && e.vppn[18:10] == o.inv_vppn[18:10] && (e.ps == 22 || e.vppn[9:0] == o.inv_vppn[9:0]);
                endcase
                if (e.e && m) begin m_arr[i].e = 0; x.writes++; end
            end
        end else begin
            w = (o.code == 3) ? (t - rel_cyc) % 16 : int'(o.idx);
            m_arr[w] = {~o.ne, o.vppn, o.ps, o.asid, o.g, o.lo0, o.lo1};
            x.writes = 1;
            x.widx = w;
        end
        x.done_cyc = t + lat;
        x.hit = m_hit; x.idx = m_idx; x.rd = m_rd;
        if (push) q.push_back(x);
        @(posedge clk); #1;
        op_valid = 0;
        drive(rnd_op());
    endtask

    // monitor: counts writes, checks idle port quiescence, and scores each done pulse
    always @(negedge clk) begin
        exp_t x;
        int bad;
        if (!resetn) wcnt = 0;
        else begin
            if (we) begin wcnt++; lw = int'(w_index); end
            if (op_ready)
                chk("idle_ports", {we, s_vppn, s_asid, r_index, w_index, w_e, w_vppn, w_ps, w_asid, w_g, w_lo0, w_lo1}, 0);
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    x = q.pop_front();
                    chk("done_cycle", cyc, x.done_cyc);
                    chk("err", err, x.err);
                    chk("write_count", wcnt, x.writes);
                    if (x.widx >= 0) chk("w_index", lw, x.widx);
                    chk("res_hit", res_hit, x.hit);
                    chk("res_index", res_index, x.idx);
                    chk("res_rd", {res_e, res_vppn, res_ps, res_asid, res_g, res_lo0, res_lo1}, x.rd);
                    bad = 0;
                    for (int i = 0; i < 16; i++) if (t_arr[i] !== m_arr[i]) bad++;
                    chk("array_entries_wrong", bad, 0);
                end
                wcnt = 0;
            end
        end
    end

    initial begin
        op_t o;
        int n, bad;
        logic [15:0] emask;
        for (int i = 0; i < 16; i++)
            m_arr[i] = {($urandom_range(0, 3) != 0), pool_vppn(), ($urandom_range(0, 1) ? 6'd12 : 6'd22),
                        10'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 26'($urandom), 26'($urandom)};
        load = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", we, 0);
        chk("rst_res", {res_hit, res_index, res_e, res_vppn, res_ps, res_asid, res_g, res_lo0, res_lo1}, 0);
        chk("rst_ports", {s_vppn, s_asid, r_index, w_index, w_e, w_vppn, w_ps, w_asid, w_g, w_lo0, w_lo1}, 0);
        @(posedge clk); #1;
        resetn = 1;
        load = 0;
        rel_cyc = cyc;
        issue(mk(3), 1);
        issue(mk(3), 1);
        o = mk(2); o.idx = 5; o.ne = 0; o.vppn = 19'h12345; o.asid = 3; o.g = 0; o.ps = 12; issue(o, 1);
        o = mk(0); o.vppn = 19'h12345; o.asid = 3; issue(o, 1);
        o.asid = 4; issue(o, 1);
        o = mk(2); o.idx = 7; o.ne = 0; o.ps = 22; issue(o, 1);
        o = mk(1); o.idx = 7; issue(o, 1);
        o = mk(2); o.idx = 1; o.ne = 0; o.vppn = 19'h12345; o.asid = 3; o.g = 0; o.ps = 12; issue(o, 1);
        o.idx = 2; o.asid = 9; o.g = 1; issue(o, 1);
        o.idx = 4; o.asid = 4; o.g = 0; issue(o, 1);
        o = mk(4); o.inv_op = 5; o.inv_asid = 3; o.inv_vppn = 19'h12345; issue(o, 1);
        o = mk(4); o.inv_op = 7; issue(o, 1);
        o = mk(0); o.code = 6; issue(o, 1);
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(rnd_op(), 1);
        end
        n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("queue_drained", q.size(), 0);
        for (int i = 0; i < 16; i++) m_arr[i].e = 1;
        load = 1;
        @(posedge clk); #1;
        load = 0;
        o = mk(4); o.inv_op = 0;
        issue(o, 0);
        repeat (8) begin @(posedge clk); #1; end
        resetn = 0;
        @(negedge clk);
        chk("abort_we", we, 0);
        @(posedge clk); #1;
        chk("abort_op_ready", op_ready, 1);
        chk("abort_done", done, 0);
        resetn = 1;
        bad = 0;
        repeat (20) begin @(negedge clk); if (we || done) bad++; end
        chk("abort_quiet", bad, 0);
        for (int i = 0; i < 16; i++) emask[i] = t_arr[i].e;
        chk("abort_e_mask", emask, 16'hFF00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
